// File: rtl/ldm_stm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ldm_stm_seq
//  Description : Block-transfer sequencer for LDM/STM. Captures the register
//                list and P/U/W/L bits, issues one beat per listed register
//                (lowest first) to the address calculator, then pulses
//                completion together with the base-writeback request.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldm_stm_seq #(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic [LIST_W-1:0] reg_list_in,
    input  logic              p_bit_in,
    input  logic              u_bit_in,
    input  logic              w_bit_in,
    input  logic              l_bit_in,
    input  logic              stall_in,
    output logic              busy_out,
    output logic              ldm_stm_en_out,
    output logic              ldm_stm_start_out,
    output logic [1:0]        func_out,
    output logic [ADDR_W-1:0] offset_out,
    output logic [3:0]        reg_num_out,
    output logic              mem_rd_out,
    output logic              mem_wr_out,
    output logic              last_beat_out,
    output logic              done_out,
    output logic              wb_en_out,
    output logic              wb_up_out,
    output logic [ADDR_W-1:0] wb_offset_out
);

    // Transfer count needs to hold 0..LIST_W inclusive.
    localparam int                c_CNT_W    = $clog2(LIST_W + 1);
    localparam logic [LIST_W-1:0] c_MASK_ONE = LIST_W'(1);
    localparam logic [ADDR_W-1:0] c_FOUR     = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LIST_W-1:0]   r_mask;
    logic                r_p;
    logic                r_u;
    logic                r_w;
    logic                r_l;
    logic                r_first;
    logic [c_CNT_W-1:0]  r_n;

    logic                w_capture;
    logic                w_advance;
    logic [c_CNT_W-1:0]  w_pop;
    logic [LIST_W-1:0]   w_mask_clr;
    logic                w_single;
    logic [3:0]          w_low_idx;
    logic [ADDR_W-1:0]   w_n4;
    logic                w_xfer;
    logic                w_done;

    // Clearing the lowest set bit: x & (x-1).
    assign w_mask_clr = r_mask & (r_mask - c_MASK_ONE);
    assign w_single   = (r_mask != '0) && (w_mask_clr == '0);
    assign w_n4       = ADDR_W'({r_n, 2'b00});
    assign w_xfer     = (r_state == S_XFER);
    assign w_done     = (r_state == S_DONE);

    // Population count of the incoming list, latched as N at capture.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LIST_W; i++) begin
            w_pop = w_pop + c_CNT_W'(reg_list_in[i]);
        end
    end

    // Priority encoder: index of the lowest set bit of the remaining mask.
    always_comb begin
        w_low_idx = 4'd0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = 4'(i);
            end
        end
    end

    // Next-state decision plus the capture/advance strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (reg_list_in == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (!stall_in) begin
                    w_advance = 1'b1;
                    if (w_single) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched request fields and the shrinking register mask.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_mask  <= '0;
            r_p     <= 1'b0;
            r_u     <= 1'b0;
            r_w     <= 1'b0;
            r_l     <= 1'b0;
            r_first <= 1'b0;
            r_n     <= '0;
        end else if (w_capture) begin
            r_mask  <= reg_list_in;
            r_p     <= p_bit_in;
            r_u     <= u_bit_in;
            r_w     <= w_bit_in;
            r_l     <= l_bit_in;
            r_first <= 1'b1;
            r_n     <= w_pop;
        end else if (w_advance) begin
            r_mask  <= w_mask_clr;
            r_first <= 1'b0;
        end
    end

    // Addressing: the first beat places the calculator at the lowest address
    // of the block so every mode walks upward in steps of 4 afterwards.
    always_comb begin
        func_out   = 2'b00;
        offset_out = '0;
        if (w_xfer) begin
            if (r_first) begin
                func_out = {1'b1, r_u};
                case ({r_p, r_u})
                    2'b01:   offset_out = '0;
                    2'b11:   offset_out = c_FOUR;
                    2'b00:   offset_out = w_n4 - c_FOUR;
                    default: offset_out = w_n4;
                endcase
            end else begin
                func_out   = 2'b11;
                offset_out = c_FOUR;
            end
        end
    end

    assign busy_out          = (r_state != S_IDLE);
    assign ldm_stm_en_out    = w_xfer;
    assign ldm_stm_start_out = w_xfer & r_first;
    assign reg_num_out       = w_xfer ? w_low_idx : 4'd0;
    assign mem_rd_out        = w_xfer & r_l;
    assign mem_wr_out        = w_xfer & ~r_l;
    assign last_beat_out     = w_xfer & w_single;
    assign done_out          = w_done;
    assign wb_en_out         = w_done & r_w;
    assign wb_up_out         = w_done & r_u;
    assign wb_offset_out     = w_done ? w_n4 : '0;

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldm_stm_seq
//  Description : Scoreboard bench for ldm_stm_seq. The driver pushes the
//                expected beat/done sequence of each block; a negedge monitor
//                pops and compares whenever the sequencer presents output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_seq;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic [15:0] reg_list_in;
    logic        p_bit_in;
    logic        u_bit_in;
    logic        w_bit_in;
    logic        l_bit_in;
    logic        stall_in;
    logic        busy_out;
    logic        ldm_stm_en_out;
    logic        ldm_stm_start_out;
    logic [1:0]  func_out;
    logic [31:0] offset_out;
    logic [3:0]  reg_num_out;
    logic        mem_rd_out;
    logic        mem_wr_out;
    logic        last_beat_out;
    logic        done_out;
    logic        wb_en_out;
    logic        wb_up_out;
    logic [31:0] wb_offset_out;

    ldm_stm_seq #(.ADDR_W(32), .LIST_W(16)) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .start_in         (start_in),
        .reg_list_in      (reg_list_in),
        .p_bit_in         (p_bit_in),
        .u_bit_in         (u_bit_in),
        .w_bit_in         (w_bit_in),
        .l_bit_in         (l_bit_in),
        .stall_in         (stall_in),
        .busy_out         (busy_out),
        .ldm_stm_en_out   (ldm_stm_en_out),
        .ldm_stm_start_out(ldm_stm_start_out),
        .func_out         (func_out),
        .offset_out       (offset_out),
        .reg_num_out      (reg_num_out),
        .mem_rd_out       (mem_rd_out),
        .mem_wr_out       (mem_wr_out),
        .last_beat_out    (last_beat_out),
        .done_out         (done_out),
        .wb_en_out        (wb_en_out),
        .wb_up_out        (wb_up_out),
        .wb_offset_out    (wb_offset_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        en;
        logic        is_done;
        logic        start;
        logic [1:0]  func;
        logic [31:0] offset;
        logic [3:0]  reg_num;
        logic        rd;
        logic        wr;
        logic        last;
        logic        wb_en;
        logic        wb_up;
        logic [31:0] wb_offset;
    } exp_t;

    exp_t sb[$];
    exp_t m_exp;
    exp_t m_act;
    int   checks = 0;
    int   errors = 0;

    // Reference model: list the registers in ascending order, then derive the
    // calculator controls for each beat and the completion record.
    task automatic push_block(input logic [15:0] list, input logic p, input logic u,
                              input logic w, input logic l);
        int   regs[$];
        int   n;
        exp_t e;
        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        n = regs.size();
        for (int k = 0; k < n; k++) begin
            e         = '0;
            e.en      = 1'b1;
            e.start   = (k == 0);
            e.reg_num = 4'(regs[k]);
            e.rd      = l;
            e.wr      = !l;
            e.last    = (k == n - 1);
            if (k == 0) begin
                e.func = u ? 2'b11 : 2'b10;
                if (!p && u)      e.offset = 32'd0;
                else if (p && u)  e.offset = 32'd4;
                else if (!p && !u) e.offset = 32'(4 * n - 4);
                else              e.offset = 32'(4 * n);
            end else begin
                e.func   = 2'b11;
                e.offset = 32'd4;
            end
            sb.push_back(e);
        end
        e           = '0;
        e.is_done   = 1'b1;
        e.wb_en     = w;
        e.wb_up     = u;
        e.wb_offset = 32'(4 * n);
        sb.push_back(e);
    endtask

    // Monitor: compares DUT output against the scoreboard head on every
    // negedge where the sequencer shows a beat or a completion.
    always @(negedge clk_in) begin
        if (!reset_in) begin
            checks++;
            if (busy_out !== (ldm_stm_en_out | done_out)) begin
                errors++;
                $display("FAIL busy got=%0b required=%0b", busy_out, ldm_stm_en_out | done_out);
            end
            if (!ldm_stm_en_out) begin
                checks++;
                if (func_out !== 2'b00 || offset_out !== 32'd0) begin
                    errors++;
                    $display("FAIL idle_addr got func=%b off=%0d required func=00 off=0",
                             func_out, offset_out);
                end
            end
            if (ldm_stm_en_out || done_out) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got en=%0b done=%0b required none",
                             ldm_stm_en_out, done_out);
                end else begin
                    m_exp         = sb[0];
                    m_act         = '0;
                    m_act.en      = ldm_stm_en_out;
                    m_act.is_done = done_out;
                    m_act.start   = ldm_stm_start_out;
                    m_act.func    = func_out;
                    m_act.offset  = offset_out;
                    m_act.wb_en   = wb_en_out;
                    if (ldm_stm_en_out) begin
                        m_act.reg_num = reg_num_out;
                        m_act.rd      = mem_rd_out;
                        m_act.wr      = mem_wr_out;
                        m_act.last    = last_beat_out;
                    end else begin
                        m_act.wb_up     = wb_up_out;
                        m_act.wb_offset = wb_offset_out;
                    end
                    if (m_act !== m_exp) begin
                        errors++;
                        $display("FAIL beat got=%h required=%h (en,done,start,func,off,reg,rd,wr,last,wben,wbup,wboff)",
                                 m_act, m_exp);
                    end
                    if (!(ldm_stm_en_out && stall_in)) void'(sb.pop_front());
                end
            end
        end
    end

    // Issue one block and wait (bounded) for its completion pulse.
    // stall_mode: 0 none, 1 random, 2 two stall cycles on the first beat.
    task automatic run_block(input logic [15:0] list, input logic p, input logic u,
                             input logic w, input logic l, input int stall_mode,
                             input bit inject);
        int cycles;
        int stalls;
        int n;
        n = $countones(list);
        push_block(list, p, u, w, l);
        reg_list_in = list;
        p_bit_in    = p;
        u_bit_in    = u;
        w_bit_in    = w;
        l_bit_in    = l;
        start_in    = 1'b1;
        @(posedge clk_in); #1;
        start_in    = 1'b0;
        reg_list_in = 16'($urandom);
        p_bit_in    = 1'($urandom);
        u_bit_in    = 1'($urandom);
        w_bit_in    = 1'($urandom);
        l_bit_in    = 1'($urandom);
        cycles = 1;
        stalls = 0;
        while (!done_out && cycles < 100) begin
            case (stall_mode)
                1:       stall_in = ($urandom % 3 == 0);
                2:       stall_in = ldm_stm_start_out && (stalls < 2);
                default: stall_in = 1'b0;
            endcase
            if (stall_in && ldm_stm_en_out) stalls++;
            start_in = inject && ldm_stm_en_out && ($urandom % 3 == 0);
            @(posedge clk_in); #1;
            cycles++;
        end
        start_in = 1'b0;
        stall_in = 1'($urandom);
        checks++;
        if (!done_out || cycles != 1 + n + stalls) begin
            errors++;
            $display("FAIL latency got done=%0b cycles=%0d required done=1 cycles=%0d",
                     done_out, cycles, 1 + n + stalls);
        end
        @(posedge clk_in); #1;
        stall_in = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy_out, ldm_stm_en_out, ldm_stm_start_out, func_out, offset_out, reg_num_out,
             mem_rd_out, mem_wr_out, last_beat_out, done_out, wb_en_out, wb_up_out,
             wb_offset_out} !== '0) begin
            errors++;
            $display("FAIL %s got busy=%0b en=%0b done=%0b off=%0d reg=%0d wboff=%0d required all zero",
                     name, busy_out, ldm_stm_en_out, done_out, offset_out, reg_num_out, wb_offset_out);
        end
    endtask

    initial begin
        reset_in    = 1'b1;
        start_in    = 1'b0;
        reg_list_in = '0;
        p_bit_in    = 1'b0;
        u_bit_in    = 1'b0;
        w_bit_in    = 1'b0;
        l_bit_in    = 1'b0;
        stall_in    = 1'b0;
        #2;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b0;

        // IA load, three beats, writeback.
        run_block(16'h000B, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        // DB store, registers 0 and 15.
        run_block(16'h8001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // DA full list.
        run_block(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        // IB with a two-cycle stall on the first beat and an ignored start.
        run_block(16'h0006, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b1);
        // Empty list.
        run_block(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);

        // Reset on beat 2 of 4 abandons the block.
        push_block(16'h00F0, 1'b0, 1'b1, 1'b1, 1'b1);
        reg_list_in = 16'h00F0;
        p_bit_in    = 1'b0;
        u_bit_in    = 1'b1;
        w_bit_in    = 1'b1;
        l_bit_in    = 1'b1;
        start_in    = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        @(posedge clk_in); #1;
        reset_in = 1'b1;
        #1;
        check_all_zero("mid_block_reset");
        sb.delete();
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        run_block(16'h0010, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);

        // Randomized blocks with random stalls and stray start pulses.
        for (int t = 0; t < 30; t++) begin
            logic [15:0] lst;
            lst = (t % 3 == 0) ? 16'($urandom & $urandom & $urandom) : 16'($urandom);
            run_block(lst, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 1'b1);
        end

        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d entries required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
